// File: rtl/id.sv
// Venus ID stage: field split, 16x32 register file with write-through bypass,
// opcode class decode, load-use hazard detection and the ID/EX latch.
module id (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        stall_i,
  input  logic        wb_i,
  input  logic [3:0]  wb_r_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] rd_value_o,
  output logic [31:0] rs_value_o,
  output logic [31:0] imm_value_o,
  output logic        immf_o,
  output logic        stall_o,
  output logic        ctrl_inte_o,
  output logic        ctrl_logic_o,
  output logic        ctrl_shift_o,
  output logic        ctrl_ld_o,
  output logic        ctrl_st_o,
  output logic        ctrl_br_o
);

  logic [6:0]  w_op;
  logic        w_immf;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs;
  logic [15:0] w_imm;
  logic [31:0] w_rd_val;
  logic [31:0] w_rs_val;
  logic [5:0]  w_ctrl;
  logic        w_hazard;

  logic [31:0] r_gr [16];
  logic [31:0] r_rd_val;
  logic [31:0] r_rs_val;
  logic [31:0] r_imm;
  logic        r_immf;
  logic [5:0]  r_ctrl;
  logic [3:0]  r_rd;

  assign w_op   = inst_i[31:25];
  assign w_immf = inst_i[24];
  assign w_rd   = inst_i[23:20];
  assign w_rs   = inst_i[19:16];
  assign w_imm  = inst_i[15:0];

  assign w_rd_val = (wb_i && (wb_r_i == w_rd)) ? wb_data_i : r_gr[w_rd];
  assign w_rs_val = (wb_i && (wb_r_i == w_rs)) ? wb_data_i : r_gr[w_rs];

  // w_ctrl bit order: {br, st, ld, shift, logic, inte}
  always_comb begin
    w_ctrl = '0;
    if      (w_op < 7'h10) w_ctrl[0] = 1'b1;
    else if (w_op < 7'h18) w_ctrl[1] = 1'b1;
    else if (w_op < 7'h20) w_ctrl[2] = 1'b1;
    else if (w_op < 7'h28) w_ctrl[3] = 1'b1;
    else if (w_op < 7'h30) w_ctrl[4] = 1'b1;
    else if (w_op < 7'h40) w_ctrl[5] = 1'b1;
  end

  assign w_hazard = r_ctrl[3] && (((!w_immf) && (r_rd == w_rs)) || (r_rd == w_rd));
  assign stall_o  = stall_i | w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gr <= '{default: '0};
    end else if (wb_i) begin
      r_gr[wb_r_i] <= wb_data_i;
    end
  end

  // Bubble only clears control/immf; data fields still load but are unused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_val <= '0;
      r_rs_val <= '0;
      r_imm    <= '0;
      r_immf   <= 1'b0;
      r_ctrl   <= '0;
      r_rd     <= '0;
    end else if (!stall_i) begin
      r_rd_val <= w_rd_val;
      r_rs_val <= w_rs_val;
      r_imm    <= {{16{w_imm[15]}}, w_imm};
      r_rd     <= w_rd;
      if (w_hazard) begin
        r_immf <= 1'b0;
        r_ctrl <= '0;
      end else begin
        r_immf <= w_immf;
        r_ctrl <= w_ctrl;
      end
    end
  end

  assign rd_value_o   = r_rd_val;
  assign rs_value_o   = r_rs_val;
  assign imm_value_o  = r_imm;
  assign immf_o       = r_immf;
  assign ctrl_inte_o  = r_ctrl[0];
  assign ctrl_logic_o = r_ctrl[1];
  assign ctrl_shift_o = r_ctrl[2];
  assign ctrl_ld_o    = r_ctrl[3];
  assign ctrl_st_o    = r_ctrl[4];
  assign ctrl_br_o    = r_ctrl[5];

endmodule

// File: tb/tb_id.sv
// Scoreboard bench for the ID stage: driver pushes model predictions, a
// monitor pops and compares stall_o and the ID/EX latch outputs each cycle.
module tb_id;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_i = '0;
  logic        stall_i = 1'b0;
  logic        wb_i = 1'b0;
  logic [3:0]  wb_r_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic        immf_o, stall_o;
  logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;

  id dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .stall_i(stall_i),
    .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
    .rd_value_o(rd_value_o), .rs_value_o(rs_value_o), .imm_value_o(imm_value_o),
    .immf_o(immf_o), .stall_o(stall_o),
    .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o), .ctrl_shift_o(ctrl_shift_o),
    .ctrl_ld_o(ctrl_ld_o), .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o)
  );

  always #5 clk = ~clk;

  // ctrl order: {br, st, ld, shift, logic, inte}
  typedef struct packed {
    logic [31:0] rdv;
    logic [31:0] rsv;
    logic [31:0] imm;
    logic        immf;
    logic [5:0]  ctrl;
    logic        bubble;
  } out_t;

  out_t        q_out[$];
  logic        q_stall[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] m_gr [16];
  out_t        m_lat;
  logic [3:0]  m_lat_rd;

  function automatic logic [5:0] op_class(input logic [6:0] op);
    int v;
    v = int'(op);
    if (v <= 15) return 6'b000001;
    if (v <= 23) return 6'b000010;
    if (v <= 31) return 6'b000100;
    if (v <= 39) return 6'b001000;
    if (v <= 47) return 6'b010000;
    if (v <= 63) return 6'b100000;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic f,
                                     input logic [3:0] rd, input logic [3:0] rs,
                                     input logic [15:0] imm);
    return {op, f, rd, rs, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus; st returns the model's predicted stall request.
  task automatic cycle(input logic r, input logic [31:0] inst, input logic si,
                       input logic w, input logic [3:0] wr, input logic [31:0] wd,
                       output logic st);
    logic [3:0]  rs, rd;
    logic        f, haz;
    logic [31:0] rsv, rdv;
    @(negedge clk);
    rst = r; inst_i = inst; stall_i = si; wb_i = w; wb_r_i = wr; wb_data_i = wd;
    if (r) begin
      for (int i = 0; i < 16; i++) m_gr[i] = '0;
      m_lat = '0;
      m_lat_rd = '0;
      st = 1'b0;
    end else begin
      rs  = inst[19:16];
      rd  = inst[23:20];
      f   = inst[24];
      rsv = (w && wr == rs) ? wd : m_gr[rs];
      rdv = (w && wr == rd) ? wd : m_gr[rd];
      haz = m_lat.ctrl[3] && ((!f && m_lat_rd == rs) || m_lat_rd == rd);
      st  = si || haz;
      if (!si) begin
        if (haz) begin
          m_lat.ctrl = '0;
          m_lat.immf = 1'b0;
          m_lat.bubble = 1'b1;
        end else begin
          m_lat.rdv = rdv;
          m_lat.rsv = rsv;
          m_lat.imm = {{16{inst[15]}}, inst[15:0]};
          m_lat.immf = f;
          m_lat.ctrl = op_class(inst[31:25]);
          m_lat.bubble = 1'b0;
          m_lat_rd = rd;
        end
      end
      if (w) m_gr[wr] = wd;
    end
    q_stall.push_back(st);
    q_out.push_back(m_lat);
  endtask

  // Present inst like IF would: repeat it while the model predicts a stall.
  task automatic issue(input logic [31:0] inst);
    logic st;
    int   tries;
    tries = 0;
    do begin
      cycle(1'b0, inst, 1'b0, 1'b0, 4'd0, 32'd0, st);
      tries++;
    end while (st && tries < 4);
  endtask

  initial begin : monitor
    logic e;
    out_t o;
    forever begin
      @(negedge clk);
      #2;
      if (q_stall.size() > 0) begin
        e = q_stall.pop_front();
        chk("stall_o", {31'd0, stall_o}, {31'd0, e});
      end
      @(posedge clk);
      #1;
      if (q_out.size() > 0) begin
        o = q_out.pop_front();
        chk("ctrl", {26'd0, ctrl_br_o, ctrl_st_o, ctrl_ld_o, ctrl_shift_o, ctrl_logic_o, ctrl_inte_o},
            {26'd0, o.ctrl});
        chk("immf_o", {31'd0, immf_o}, {31'd0, o.immf});
        if (!o.bubble) begin
          chk("rd_value_o", rd_value_o, o.rdv);
          chk("rs_value_o", rs_value_o, o.rsv);
          chk("imm_value_o", imm_value_o, o.imm);
        end
      end
    end
  end

  initial begin : driver
    logic        st;
    logic [31:0] cur;
    logic [6:0]  op;
    for (int i = 0; i < 16; i++) m_gr[i] = '0;
    m_lat = '0;
    m_lat_rd = '0;
    #1 rst = 1'b1;

    cycle(1'b1, 32'h0, 1'b0, 1'b0, 4'd0, 32'd0, st);
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 4'd0, 32'd0, st);

    // write-back, then read the same register on both ports
    cycle(1'b0, mk(7'h40, 1'b0, 4'd0, 4'd0, 16'h0), 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, st);
    cycle(1'b0, mk(7'h01, 1'b0, 4'd3, 4'd3, 16'h0), 1'b0, 1'b0, 4'd0, 32'd0, st);
    // same-cycle write-through bypass
    cycle(1'b0, mk(7'h01, 1'b0, 4'd1, 4'd5, 16'h0), 1'b0, 1'b1, 4'd5, 32'h12345678, st);

    // class/immediate sweep
    for (int unsigned k = 1; k <= 32; k++) begin
      op = 7'(k);
      issue(mk(op, op[0], op[3:0], 4'(k + 1), 16'h8001));
    end

    // load-use: ld r2, then add using r2
    issue(mk(7'h20, 1'b0, 4'd2, 4'd0, 16'h0004));
    issue(mk(7'h01, 1'b0, 4'd7, 4'd2, 16'h0));

    // downstream stall for 3 cycles with changing inst and write-back
    issue(mk(7'h11, 1'b1, 4'd4, 4'd6, 16'h7FFF));
    cycle(1'b0, mk(7'h30, 1'b0, 4'd8, 4'd9, 16'h1234), 1'b1, 1'b1, 4'd9, 32'hCAFEF00D, st);
    cycle(1'b0, mk(7'h28, 1'b1, 4'd9, 4'd8, 16'hF00F), 1'b1, 1'b0, 4'd0, 32'd0, st);
    cycle(1'b0, mk(7'h18, 1'b0, 4'd1, 4'd2, 16'h0F0F), 1'b1, 1'b1, 4'd15, 32'h0BADCAFE, st);
    issue(mk(7'h02, 1'b0, 4'd15, 4'd9, 16'h0));

    // stall_i during a load-use hazard: hold wins over the bubble
    issue(mk(7'h21, 1'b0, 4'd6, 4'd0, 16'h0));
    cycle(1'b0, mk(7'h05, 1'b0, 4'd1, 4'd6, 16'h0), 1'b1, 1'b0, 4'd0, 32'd0, st);
    issue(mk(7'h05, 1'b0, 4'd1, 4'd6, 16'h0));

    // reset mid-stream, then normal decode
    issue(mk(7'h22, 1'b0, 4'd3, 4'd3, 16'h0));
    cycle(1'b1, mk(7'h03, 1'b0, 4'd3, 4'd3, 16'h0), 1'b0, 1'b0, 4'd0, 32'd0, st);
    issue(mk(7'h03, 1'b0, 4'd3, 4'd3, 16'h8000));

    // randomized traffic with IF holding the instruction on stall
    st  = 1'b0;
    cur = '0;
    for (int n = 0; n < 600; n++) begin
      if (!st) begin
        case ($urandom_range(0, 3))
          0:       op = 7'($urandom_range(32, 39));
          1:       op = 7'($urandom_range(0, 127));
          default: op = 7'($urandom_range(0, 63));
        endcase
        cur = mk(op, 1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 16'($urandom));
      end
      if ($urandom_range(0, 99) == 0)
        cycle(1'b1, cur, 1'b0, 1'b0, 4'd0, 32'd0, st);
      else
        cycle(1'b0, cur, ($urandom_range(0, 4) == 0), 1'($urandom),
              4'($urandom_range(0, 7)), $urandom, st);
    end

    cycle(1'b0, mk(7'h40, 1'b0, 4'd0, 4'd0, 16'h0), 1'b0, 1'b0, 4'd0, 32'd0, st);
    repeat (3) @(negedge clk);
    n_tests++;
    if (q_out.size() != 0 || q_stall.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d/%0d left expected 0/0", q_out.size(), q_stall.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
